jk_down_counter: RTL and testbench

Synchronous down counter built from JK flip-flop cells, the counting-direction complement of the team's JK up counter. Each bit is a JK cell whose J/K inputs come from borrow-chain logic. Parallel load, count enable, a zero flag and a one-cycle borrow pulse are provided. It serves as a countdown timer and terminal-count source next to the up-counter blocks.

---
 rtl/jk_pkg.sv | 11 +
 rtl/jk_cell.sv | 25 ++
 rtl/jk_down_counter.sv | 83 ++++++++
 tb/tb_jk_down_counter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// Shared JK flip-flop mode encoding (J is the MSB) for the JK counter blocks.
package jk_pkg;

   typedef enum logic [1:0] {
      JK_HOLD = 2'b00,
      JK_CLR  = 2'b01,
      JK_SET  = 2'b10,
      JK_TGL  = 2'b11
   } jk_mode_t;

endpackage : jk_pkg

// File: rtl/jk_cell.sv
// Single JK flip-flop with asynchronous active-high reset.
module jk_cell
   import jk_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic j,
   input  logic k,
   output logic q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         q <= 1'b0;
      end else begin
         case (jk_mode_t'({j, k}))
            JK_HOLD: q <= q;
            JK_CLR:  q <= 1'b0;
            JK_SET:  q <= 1'b1;
            JK_TGL:  q <= ~q;
         endcase
      end
   end

endmodule : jk_cell

// File: rtl/jk_down_counter.sv
// Synchronous down counter of JK cells with parallel load, zero flag and borrow pulse.
// Define JK_DOWN_AUTORELOAD_EN to reload from the last loaded value on underflow.
module jk_down_counter
   import jk_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] q,
   output logic             zero,
   output logic             borrow
);

   logic [WIDTH-1:0] w_q;
   logic [WIDTH-1:0] w_j;
   logic [WIDTH-1:0] w_k;
   logic             w_uflow;
   logic             r_borrow;

`ifdef JK_DOWN_AUTORELOAD_EN
   logic [WIDTH-1:0] r_reload;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_reload <= '0;
      end else if (load) begin
         r_reload <= din;
      end
   end
`endif

   assign w_uflow = en & ~load & (w_q == '0);

   // Load steering, else borrow chain: a bit toggles when every lower bit is zero.
   always_comb begin
      logic w_run;
      w_j   = '0;
      w_k   = '0;
      w_run = 1'b1;
      if (load) begin
         w_j = din;
         w_k = ~din;
`ifdef JK_DOWN_AUTORELOAD_EN
      end else if (w_uflow) begin
         w_j = r_reload;
         w_k = ~r_reload;
`endif
      end else if (en) begin
         for (int unsigned i = 0; i < WIDTH; i++) begin
            w_j[i] = w_run;
            w_k[i] = w_run;
            w_run  = w_run & ~w_q[i];
         end
      end
   end

   for (genvar g = 0; g < WIDTH; g++) begin : gen_cell
      jk_cell u_cell (
         .clk (clk),
         .rst (rst),
         .j   (w_j[g]),
         .k   (w_k[g]),
         .q   (w_q[g])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_borrow <= 1'b0;
      end else begin
         r_borrow <= w_uflow;
      end
   end

   assign q      = w_q;
   assign zero   = (w_q == '0);
   assign borrow = r_borrow;

endmodule : jk_down_counter

// File: tb/tb_jk_down_counter.sv
// Self-checking bench for jk_down_counter (WIDTH=3) against a behavioural countdown model.
module tb_jk_down_counter;

   localparam int unsigned WIDTH = 3;
   localparam int unsigned MAXV  = (1 << WIDTH) - 1;

   logic             clk;
   logic             rst;
   logic             en;
   logic             load;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] q;
   logic             zero;
   logic             borrow;

   int unsigned errors = 0;
   int unsigned checks = 0;

   int unsigned m_q   = 0;
   int unsigned m_rld = 0;
   bit          m_b   = 1'b0;

`ifdef JK_DOWN_AUTORELOAD_EN
   localparam bit AUTO = 1'b1;
`else
   localparam bit AUTO = 1'b0;
`endif

   jk_down_counter #(.WIDTH(WIDTH)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .load   (load),
      .din    (din),
      .q      (q),
      .zero   (zero),
      .borrow (borrow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".q"}, int'(q), m_q);
      chk({tag, ".zero"}, int'(zero), (m_q == 0) ? 1 : 0);
      chk({tag, ".borrow"}, int'(borrow), int'(m_b));
   endtask

   // One clock: drive on negedge, advance the model at posedge, sample 1ns later.
   task automatic step(input bit l, input bit e, input int unsigned d, input string tag);
      @(negedge clk);
      load = l;
      en   = e;
      din  = WIDTH'(d);
      @(posedge clk);
      if (l) begin
         m_q   = d & MAXV;
         m_rld = d & MAXV;
         m_b   = 1'b0;
      end else if (e) begin
         m_b = (m_q == 0);
         if (m_b) m_q = AUTO ? m_rld : MAXV;
         else     m_q = m_q - 1;
      end else begin
         m_b = 1'b0;
      end
      #1;
      chk_all(tag);
   endtask

   initial begin
      rst  = 1'b1;
      en   = 1'b0;
      load = 1'b0;
      din  = '0;
      #2;
      chk_all("reset_noclk");

      @(negedge clk);
      rst = 1'b0;
      m_q = 0; m_rld = 0; m_b = 1'b0;

      // First decrement from reset wraps
      step(1'b0, 1'b1, 0, "first_wrap");
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 0, "countdown");

      // Load priority over enable
      step(1'b1, 1'b0, 4, "load4");
      step(1'b1, 1'b1, 5, "load_pri");
      step(1'b0, 1'b1, 0, "after_load");

      // Hold
      step(1'b1, 1'b0, 3, "load3");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, "hold");

      // Load while zero with enable: no borrow
      step(1'b1, 1'b0, 0, "load0");
      step(1'b1, 1'b1, 0, "load0_en");

      // Async reset mid-count with pending borrow
      step(1'b1, 1'b0, 5, "load5");
      step(1'b1, 1'b0, 0, "load0b");
      step(1'b0, 1'b1, 0, "wrap_pending");
      @(negedge clk);
      en = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      m_q = 0; m_rld = 0; m_b = 1'b0;
      chk_all("async_rst");
      @(negedge clk);
      rst = 1'b0;
      step(1'b0, 1'b0, 0, "post_rst");

      // Load then count to underflow
      step(1'b1, 1'b0, 2, "load2");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, "to_uflow");

      // Reload-value scenarios (wrap to all-ones when reload is absent)
      step(1'b1, 1'b0, 3, "load3r");
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 0, "reload3");
      step(1'b1, 1'b0, 0, "load0r");
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 0, "reload0");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(7) == 0), ($urandom_range(3) != 0),
              $urandom_range(MAXV), "rand");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_jk_down_counter
